// File: rtl/icache_pkg.sv
// Shared widths, state encoding and address-split helpers for the
// direct-mapped instruction cache.
package icache_pkg;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 16;
   localparam int INDEX_BITS  = 4;
   localparam int OFFSET_BITS = 2;
   localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int LINE_WORDS  = 4;
   localparam int NUM_LINES   = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS +: INDEX_BITS];
   endfunction

   function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS-1:0];
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, plus the
// FSM state exported for observation.
//
// Handshakes: fetch side has no valid; pc is presented every cycle and
// i_rdy=1 means instr is valid for that pc in the same cycle. Memory side:
// mem_rd_req is a level held for the whole fill with mem_addr stable, and
// every cycle with mem_rd_valid=1 during the fill delivers one beat, in
// word-offset order 0..3.
interface icache_if;
   import icache_pkg::*;

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instr;
   logic              i_rdy;
   logic              invalidate;
   logic              mem_rd_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rdata;
   state_e            dbg_state;

   modport slave (
      input  pc, invalidate, mem_rd_valid, mem_rdata,
      output instr, i_rdy, mem_rd_req, mem_addr, dbg_state
   );

   modport master (
      output pc, invalidate, mem_rd_valid, mem_rdata,
      input  instr, i_rdy, mem_rd_req, mem_addr, dbg_state
   );

endinterface

// File: rtl/icache_data_ram.sv
// Cache data store: one synchronous write port for refill beats and one
// asynchronous read port so hits complete in the same cycle.
module icache_data_ram
   import icache_pkg::*;
(
   input  logic                   clk,
   input  logic                   i_we,
   input  logic [INDEX_BITS-1:0]  i_wr_index,
   input  logic [OFFSET_BITS-1:0] i_wr_offset,
   input  logic [DATA_W-1:0]      i_wr_data,
   input  logic [INDEX_BITS-1:0]  i_rd_index,
   input  logic [OFFSET_BITS-1:0] i_rd_offset,
   output logic [DATA_W-1:0]      o_rd_data
);

   logic [DATA_W-1:0] r_mem [NUM_LINES*LINE_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[{i_wr_index, i_wr_offset}] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[{i_rd_index, i_rd_offset}];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache between the PC register and the memory
// arbiter; misses refill a 4-word line through a burst read.
module icache_fetch
   import icache_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   icache_if.slave  bus
);

   localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(LINE_WORDS - 1);

   state_e                 r_state;
   logic [NUM_LINES-1:0]   r_valid;
   logic [TAG_W-1:0]       r_tag_arr [NUM_LINES];
   logic [OFFSET_BITS-1:0] r_beat_cnt;
   logic [ADDR_W-1:0]      r_fill_addr;
   logic                   r_mem_rd_req;
   logic                   r_kill_fill;

   logic [TAG_W-1:0]       w_tag;
   logic [INDEX_BITS-1:0]  w_index;
   logic [OFFSET_BITS-1:0] w_offset;
   logic [INDEX_BITS-1:0]  w_fill_index;
   logic [DATA_W-1:0]      w_rd_data;
   logic                   w_hit;
   logic                   w_beat_we;
   logic                   w_last_beat;

   assign w_tag        = addr_tag(bus.pc);
   assign w_index      = addr_index(bus.pc);
   assign w_offset     = addr_offset(bus.pc);
   assign w_fill_index = addr_index(r_fill_addr);
   assign w_hit        = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);
   assign w_beat_we    = (r_state == FILL) && bus.mem_rd_valid;
   assign w_last_beat  = w_beat_we && (r_beat_cnt == LAST_BEAT);

   icache_data_ram u_data_ram (
      .clk         (clk),
      .i_we        (w_beat_we),
      .i_wr_index  (w_fill_index),
      .i_wr_offset (r_beat_cnt),
      .i_wr_data   (bus.mem_rdata),
      .i_rd_index  (w_index),
      .i_rd_offset (w_offset),
      .o_rd_data   (w_rd_data)
   );

   // Tags are written regardless of a kill; valid alone decides usability.
   always_ff @(posedge clk) begin
      if (w_last_beat) begin
         r_tag_arr[w_fill_index] <= addr_tag(r_fill_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_beat_cnt   <= '0;
         r_fill_addr  <= '0;
         r_mem_rd_req <= 1'b0;
         r_kill_fill  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.invalidate) begin
                  r_valid <= '0;
               end
               if (!w_hit) begin
                  r_fill_addr  <= {bus.pc[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  r_beat_cnt   <= '0;
                  r_mem_rd_req <= 1'b1;
                  r_state      <= FILL;
               end
            end
            FILL: begin
               if (bus.invalidate) begin
                  r_valid     <= '0;
                  r_kill_fill <= 1'b1;
               end
               if (w_beat_we) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
               // An invalidate on the last beat overrides the fresh valid bit.
               if (w_last_beat) begin
                  r_valid[w_fill_index] <= !(r_kill_fill || bus.invalidate);
                  r_mem_rd_req          <= 1'b0;
                  r_state               <= DONE;
               end
            end
            DONE: begin
               if (bus.invalidate) begin
                  r_valid <= '0;
               end
               r_kill_fill <= 1'b0;
               r_state     <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.i_rdy      = rst_n && (r_state == IDLE) && w_hit;
   assign bus.instr      = bus.i_rdy ? w_rd_data : '0;
   assign bus.mem_rd_req = r_mem_rd_req;
   assign bus.mem_addr   = r_fill_addr;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, conflict, gapped refill,
// invalidate and flow change mid-fill, and reset mid-fill.
module tb_icache_fetch;
   import icache_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_passed;

   icache_if bus ();

   icache_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hit(input logic [15:0] addr, input logic [15:0] exp);
      bus.pc = addr;
      #1;
      chk("hit_rdy", 32'(bus.i_rdy), 32'd1);
      chk("hit_instr", 32'(bus.instr), 32'(exp));
      chk("hit_noreq", 32'(bus.mem_rd_req), 32'd0);
      cyc();
   endtask

   task automatic miss(input logic [15:0] addr);
      bus.pc = addr;
      #1;
      chk("miss_rdy", 32'(bus.i_rdy), 32'd0);
      chk("miss_state", 32'(bus.dbg_state), 32'(IDLE));
   endtask

   // Entered in the miss cycle; returns at the start of the first IDLE cycle.
   task automatic fill(input logic [15:0] base, input logic [15:0] d0, input int gap,
                       input int inv_beat, input logic [15:0] pc_after);
      cyc();
      bus.pc = pc_after;
      #1;
      chk("fill_req", 32'(bus.mem_rd_req), 32'd1);
      chk("fill_addr", 32'(bus.mem_addr), 32'(base));
      chk("fill_rdy", 32'(bus.i_rdy), 32'd0);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < gap; g++) begin
            cyc();
            bus.mem_rd_valid = 1'b0;
            bus.invalidate   = 1'b0;
            #1;
            chk("gap_req", 32'(bus.mem_rd_req), 32'd1);
         end
         cyc();
         bus.mem_rd_valid = 1'b1;
         bus.mem_rdata    = 16'(d0 + 16'(b));
         bus.invalidate   = (b == inv_beat);
         #1;
         chk("beat_rdy", 32'(bus.i_rdy), 32'd0);
      end
      cyc();
      bus.mem_rd_valid = 1'b0;
      bus.invalidate   = 1'b0;
      #1;
      chk("done_req", 32'(bus.mem_rd_req), 32'd0);
      chk("done_rdy", 32'(bus.i_rdy), 32'd0);
      chk("done_state", 32'(bus.dbg_state), 32'(DONE));
      cyc();
   endtask

   initial begin
      n_checks         = 0;
      n_passed         = 0;
      rst_n            = 1'b0;
      bus.pc           = 16'h0000;
      bus.invalidate   = 1'b0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rdata    = 16'h0000;

      // Reset state
      cyc();
      cyc();
      chk("rst_rdy", 32'(bus.i_rdy), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_req", 32'(bus.mem_rd_req), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // Cold miss, gapless refill, then the rest of the line hits
      miss(16'h0000);
      chk("cold_req0", 32'(bus.mem_rd_req), 32'd0);
      fill(16'h0000, 16'hA000, 0, -1, 16'h0000);
      chk("cold_state", 32'(bus.dbg_state), 32'(IDLE));
      hit(16'h0000, 16'hA000);
      bus.mem_rd_valid = 1'b1;
      bus.mem_rdata    = 16'hFFFF;
      hit(16'h0001, 16'hA001);
      bus.mem_rd_valid = 1'b0;
      hit(16'h0002, 16'hA002);
      hit(16'h0003, 16'hA003);
      hit(16'h0000, 16'hA000);

      // Conflict on index 0
      miss(16'h0040);
      fill(16'h0040, 16'hB000, 0, -1, 16'h0040);
      hit(16'h0040, 16'hB000);
      hit(16'h0043, 16'hB003);
      miss(16'h0000);
      fill(16'h0000, 16'hA000, 0, -1, 16'h0000);
      hit(16'h0002, 16'hA002);

      // Gapped beats
      miss(16'h0008);
      fill(16'h0008, 16'hC000, 3, -1, 16'h0008);
      hit(16'h0008, 16'hC000);
      hit(16'h0009, 16'hC001);
      hit(16'h000A, 16'hC002);
      hit(16'h000B, 16'hC003);

      // Invalidate during the second beat kills the fill and older lines
      miss(16'h0010);
      fill(16'h0010, 16'hD000, 0, 1, 16'h0010);
      miss(16'h0010);
      fill(16'h0010, 16'hD000, 0, -1, 16'h0010);
      hit(16'h0011, 16'hD001);
      miss(16'h0000);
      fill(16'h0000, 16'hA000, 0, -1, 16'h0000);
      hit(16'h0003, 16'hA003);

      // Invalidate in IDLE, then flow change during the fill
      bus.pc         = 16'h0000;
      bus.invalidate = 1'b1;
      #1;
      chk("inv_idle_rdy", 32'(bus.i_rdy), 32'd1);
      cyc();
      bus.invalidate = 1'b0;
      miss(16'h0010);
      fill(16'h0010, 16'hE000, 0, -1, 16'h0025);
      miss(16'h0025);
      fill(16'h0024, 16'hF000, 0, -1, 16'h0025);
      hit(16'h0025, 16'hF001);
      hit(16'h0010, 16'hE000);
      hit(16'h0013, 16'hE003);

      // Reset mid-fill
      miss(16'h0014);
      cyc();
      #1;
      chk("rf_req", 32'(bus.mem_rd_req), 32'd1);
      chk("rf_addr", 32'(bus.mem_addr), 32'h0014);
      cyc();
      bus.mem_rd_valid = 1'b1;
      bus.mem_rdata    = 16'h5555;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rf_req_drop", 32'(bus.mem_rd_req), 32'd0);
      chk("rf_rdy", 32'(bus.i_rdy), 32'd0);
      chk("rf_state", 32'(bus.dbg_state), 32'(IDLE));
      bus.mem_rd_valid = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      miss(16'h0010);
      fill(16'h0010, 16'h1230, 0, -1, 16'h0010);
      hit(16'h0012, 16'h1232);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
